// File: rtl/qspi_ram_responder_if.sv
// qspi_ram_responder_if: quad-SPI pad bundle between a controller (master) and the RAM responder (slave)
interface qspi_ram_responder_if;
    logic       qspi_clk;
    logic       qspi_select;
    logic [3:0] qspi_data_in;
    logic [3:0] qspi_data_out;
    logic [3:0] qspi_data_oe;
    modport master (output qspi_clk, qspi_select, qspi_data_in, input qspi_data_out, qspi_data_oe);
    modport slave (input qspi_clk, qspi_select, qspi_data_in, output qspi_data_out, qspi_data_oe);
endinterface

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: quad-SPI RAM target serving 0xEB reads and 0x38 writes from an internal byte array
module qspi_ram_responder #(
    parameter int MEM_BYTES     = 256,
    parameter int DUMMY_NIBBLES = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    qspi_ram_responder_if.slave  bus,
    output logic                 busy,
    output logic                 bad_cmd
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = $clog2((DUMMY_NIBBLES > 6 ? DUMMY_NIBBLES : 6) + 1);
    localparam logic [CW-1:0] DN = CW'(DUMMY_NIBBLES);
    localparam logic [CW-1:0] LAST_ADDR = CW'(5);
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DUMMY = 3'd3,
                           READ = 3'd4, WRITE = 3'd5, IGNORE = 3'd6;

    logic          clk_q, clk_prev_q, sel_q;
    logic [3:0]    din_q;
    logic [7:0]    mem [MEM_BYTES];
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [3:0]    hold_q, hold_d, dout_q, dout_d;
    logic          phase_q, phase_d, rd_q, rd_d, armed_q, armed_d, oe_q, oe_d, bad_q, bad_d, we;
    logic          rise, fall, cmd_rd, cmd_wr;
    logic [7:0]    byte_in;

    assign rise     = clk_q & ~clk_prev_q;
    assign fall     = ~clk_q & clk_prev_q;
    assign byte_in  = {hold_q, din_q};
    assign cmd_rd   = byte_in == 8'hEB;
    assign cmd_wr   = byte_in == 8'h38;
    assign addr_inc = addr_q + 1'b1;

    always_ff @(posedge clock) begin
        clk_q      <= bus.qspi_clk;
        clk_prev_q <= clk_q;
        sel_q      <= bus.qspi_select;
        din_q      <= bus.qspi_data_in;
    end

    // armed_q stays low until select is seen high after reset, so a frame cut by reset is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        bad_d   = 1'b0;
        we      = 1'b0;
        armed_d = armed_q | sel_q;
        if (sel_q) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = armed_q ? CMD : IGNORE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                CMD: if (rise) begin
                    hold_d = din_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d   = '0;
                        rd_d    = cmd_rd;
                        state_d = (cmd_rd | cmd_wr) ? ADDR : IGNORE;
                        bad_d   = ~(cmd_rd | cmd_wr);
                    end
                end
                ADDR: if (rise) begin
                    addr_d  = {addr_q[AW-5:0], din_q};
                    cnt_d   = cnt_q == LAST_ADDR ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == LAST_ADDR ? (rd_q ? DUMMY : WRITE) : ADDR;
                end
                DUMMY: begin
                    if (rise && cnt_q != DN) cnt_d = cnt_q + 1'b1;
                    else if (fall && cnt_q == DN) begin
                        dout_d  = mem[addr_q][7:4];
                        oe_d    = 1'b1;
                        phase_d = 1'b0;
                        state_d = READ;
                    end
                end
                READ: if (fall) begin
                    phase_d = ~phase_q;
                    dout_d  = phase_q ? mem[addr_inc][7:4] : mem[addr_q][3:0];
                    addr_d  = phase_q ? addr_inc : addr_q;
                end
                WRITE: if (rise) begin
                    phase_d = ~phase_q;
                    hold_d  = din_q;
                    we      = phase_q;
                    addr_d  = phase_q ? addr_inc : addr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            phase_q <= 1'b0;
            rd_q    <= 1'b0;
            armed_q <= 1'b0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            phase_q <= phase_d;
            rd_q    <= rd_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            bad_q   <= bad_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we && !reset) mem[addr_q] <= byte_in;
    end

    assign bus.qspi_data_out = dout_q;
    assign bus.qspi_data_oe  = {4{oe_q}};
    assign busy              = state_q != IDLE;
    assign bad_cmd           = bad_q;
endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: drives quad-SPI frames and scores read nibbles against a byte-array model
module tb_qspi_ram_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy, bad_cmd;
    int n_vec = 0, n_err = 0, bad_cnt = 0;
    logic [3:0] exp_q[$];
    logic [7:0] model [256];

    qspi_ram_responder_if bus ();

    qspi_ram_responder #(.MEM_BYTES(256), .DUMMY_NIBBLES(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .bad_cmd (bad_cmd)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (bad_cmd) bad_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        bus.qspi_data_in = n;
        repeat (4) @(negedge clock);
        check("oe_off", 32'(bus.qspi_data_oe), 32'h0);
        bus.qspi_clk = 1'b1;
        repeat (4) @(negedge clock);
        bus.qspi_clk = 1'b0;
    endtask

    task automatic read_nib();
        logic [3:0] e;
        repeat (4) @(negedge clock);
        if (exp_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
        else begin
            e = exp_q.pop_front();
            check("rd_nib", 32'(bus.qspi_data_out), 32'(e));
        end
        check("rd_oe", 32'(bus.qspi_data_oe), 32'hF);
        bus.qspi_clk = 1'b1;
        repeat (4) @(negedge clock);
        bus.qspi_clk = 1'b0;
    endtask

    task automatic frame_start(input logic [7:0] cmd, input logic [23:0] a);
        @(negedge clock);
        bus.qspi_clk    = 1'b0;
        bus.qspi_select = 1'b0;
        send_nib(cmd[7:4]);
        send_nib(cmd[3:0]);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic deselect();
        @(negedge clock);
        bus.qspi_clk    = 1'b0;
        bus.qspi_select = 1'b1;
        repeat (3) @(negedge clock);
        check("desel_oe", 32'(bus.qspi_data_oe), 32'h0);
        check("desel_busy", 32'(busy), 32'd0);
    endtask

    task automatic write_frame(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1, input int nb);
        logic [7:0] b;
        frame_start(8'h38, a);
        for (int i = 0; i < nb; i++) begin
            b = (i == 0) ? b0 : b1;
            send_nib(b[7:4]);
            send_nib(b[3:0]);
            model[a[7:0] + 8'(i)] = b;
        end
        deselect();
    endtask

    task automatic read_frame(input logic [23:0] a, input int n);
        logic [7:0] b;
        frame_start(8'hEB, a);
        for (int k = 0; k < n; k++) begin
            b = model[a[7:0] + 8'(k / 2)];
            exp_q.push_back((k % 2 == 1) ? b[3:0] : b[7:4]);
        end
        repeat (6) send_nib(4'h0);
        for (int k = 0; k < n; k++) read_nib();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0;
        bus.qspi_clk     = 1'b0;
        bus.qspi_select  = 1'b1;
        bus.qspi_data_in = 4'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_oe", 32'(bus.qspi_data_oe), 32'h0);
        check("rst_dout", 32'(bus.qspi_data_out), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bad", 32'(bad_cmd), 32'd0);

        write_frame(24'h000010, 8'hA5, 8'h3C, 2);
        read_frame(24'h000010, 4);
        deselect();

        write_frame(24'h0000FF, 8'h11, 8'h22, 2);
        read_frame(24'h0000FF, 4);
        deselect();
        read_frame(24'h000000, 2);
        deselect();
        read_frame(24'h1000FF, 2);
        deselect();

        b0 = bad_cnt;
        frame_start(8'h9F, 24'h000010);
        send_nib(4'h5);
        send_nib(4'hA);
        deselect();
        check("bad_pulse_cycles", 32'(bad_cnt - b0), 32'd1);
        read_frame(24'h000010, 2);
        deselect();

        write_frame(24'h000020, 8'h77, 8'h00, 1);
        frame_start(8'h38, 24'h000020);
        send_nib(4'h5);
        deselect();
        read_frame(24'h000020, 2);
        deselect();

        read_frame(24'h000010, 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst6_oe", 32'(bus.qspi_data_oe), 32'h0);
        check("rst6_dout", 32'(bus.qspi_data_out), 32'h0);
        check("rst6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_oe", 32'(bus.qspi_data_oe), 32'h0);
        send_nib(4'hE);
        send_nib(4'hB);
        check("ign_busy_hold", 32'(busy), 32'd1);
        deselect();
        read_frame(24'h000010, 4);
        deselect();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
